// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan driver.
//   SEG_BLANK / SEG_DASH / SEG_E / SEG_R : fixed glyphs, active-low {g,f,e,d,c,b,a}
//   AN_OFF                               : all anodes off (active-low)
//   snap_t / SNAP_RESET                  : per-frame input snapshot and its reset value
//   hex_font()                           : nibble -> active-low hex glyph (0-9, A, b, C, d, E, F)
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef struct packed {
    logic [15:0] value;
    logic [6:0]  size;
    logic        empty;
    logic        error;
    logic        show_size;
  } snap_t;

  // After reset the display reads as an empty stack.
  localparam snap_t SNAP_RESET = '{value: 16'h0000, size: 7'h00, empty: 1'b1,
                                   error: 1'b0, show_size: 1'b0};

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_font.sv
// seg7_font: combinational hex font lookup.
//   nib : 4-bit nibble to display
//   seg : active-low segment pattern {g,f,e,d,c,b,a}
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_font(nib);

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 4-digit common-anode seven-segment driver.
// Inputs are snapshotted once per scan frame (at the end of digit 3) so a
// frame never mixes old and new data.
//   clk, rst_n      : clock, asynchronous active-low reset
//   value[15:0]     : value shown as 4 hex digits
//   size[6:0]       : stack size, shown when show_size=1
//   empty, error    : stack empty / calculator error flags
//   show_size       : 1 = size view, 0 = value view
//   an[3:0]         : active-low anodes, an[0] = rightmost digit
//   seg[6:0]        : active-low segments {g,f,e,d,c,b,a}
//   dp              : active-low decimal point
// Optional build macro SEG7_BLINK_EN: error glyphs blink, off for the upper
// half of every 2^BLINK_W frames.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int BLINK_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [6:0]  size,
  input  logic        empty,
  input  logic        error,
  input  logic        show_size,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [DIV_W-1:0] pcnt;
  logic [1:0]       dig;
  snap_t            snap;
  logic             tick;
  logic             frame_end;

  assign tick      = &pcnt;
  assign frame_end = tick && (dig == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      dig  <= 2'd0;
      snap <= SNAP_RESET;
    end else begin
      pcnt <= pcnt + DIV_W'(1);
      if (tick) dig <= dig + 2'd1;
      if (frame_end) begin
        snap <= '{value: value, size: size, empty: empty,
                  error: error, show_size: show_size};
      end
    end
  end

  logic blink_off;

`ifdef SEG7_BLINK_EN
  // Free-running frame counter; deliberately not cleared when error rises.
  logic [BLINK_W-1:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
    end else if (frame_end) begin
      fcnt <= fcnt + BLINK_W'(1);
    end
  end

  assign blink_off = snap.error && fcnt[BLINK_W-1];
`else
  // Steady error glyphs; BLINK_W only matters in the blinking build.
  assign blink_off = (BLINK_W < 0);
`endif

  // Glyph selection for the digit currently being scanned.
  logic [3:0] nib;
  logic       use_font;
  logic [6:0] glyph;
  logic       dp_next;
  logic [6:0] font_seg;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  always_comb begin
    nib      = 4'h0;
    use_font = 1'b0;
    glyph    = SEG_BLANK;
    dp_next  = 1'b1;
    if (snap.error) begin
      case (dig)
        2'd3:       glyph = SEG_E;
        2'd2, 2'd1: glyph = SEG_R;
        default:    glyph = SEG_BLANK;
      endcase
    end else if (snap.empty) begin
      glyph = SEG_DASH;
    end else if (snap.show_size) begin
      case (dig)
        2'd0: begin
          nib      = snap.size[3:0];
          use_font = 1'b1;
          dp_next  = 1'b0;
        end
        2'd1: begin
          nib      = {1'b0, snap.size[6:4]};
          use_font = 1'b1;
        end
        default: glyph = SEG_BLANK;
      endcase
    end else begin
      use_font = 1'b1;
      case (dig)
        2'd0:    nib = snap.value[3:0];
        2'd1:    nib = snap.value[7:4];
        2'd2:    nib = snap.value[11:8];
        default: nib = snap.value[15:12];
      endcase
    end
  end

  seg7_font u_font (
    .nib (nib),
    .seg (font_seg)
  );

  assign seg_next = use_font ? font_seg : glyph;
  assign an_next  = blink_off ? AN_OFF : ~(4'b0001 << dig);

  // Registered outputs: one cycle behind dig and the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed 4-digit seven-segment display driver on the output side of the calculator core. Consumes the calculator's top-of-stack value, stack size, empty and error flags, and scans them onto a common-anode display with active-low anode and segment lines. Inputs are snapshotted once per scan frame so the display never tears mid-frame. Error and empty conditions get dedicated glyphs.

## Interface
- `DIV_W`, 16: prescaler width; each digit is lit for 2^DIV_W cycles.
- `BLINK_W`, 6: frame-counter width for error blink; the blink period is 2^BLINK_W frames.
- `clk` in 1: the single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 16: value to display, as hex.
- `size` in 7: stack size.
- `empty` in 1: stack empty flag.
- `error` in 1: calculator error flag.
- `show_size` in 1: 1 selects stack-size view instead of value view.
- `an` out 4: digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Prescaler `pcnt` (DIV_W bits) increments every cycle. `tick` is asserted when `pcnt` is all ones.
- Digit index `dig` (2 bits) increments on `tick` and wraps 3→0.
- Snapshot: on `tick && dig==3`, register `value`, `size`, `empty`, `error`, `show_size`. All digits of a frame use the same snapshot.
- Glyph selection per digit `d`, highest priority first:
  - snapshot error: digits 3..0 = "E","r","r",blank. E = a,d,e,f,g. r = e,g.
  - snapshot empty: all four digits show "-" (g only).
  - show_size: digits 3,2 blank; digit 1 = hex `{1'b0,size[6:4]}`; digit 0 = hex `size[3:0]`; dp lit on digit 0 only.
  - otherwise: digit d = hex `value[4d+3:4d]`; dp off.
- Hex font is standard: 0-9, A, b, C, d, E, F.
- Exactly one anode is low at any time outside reset and blink-off.

## Timing
- Reset (async assert on `rst_n` low) sets:
  - `pcnt`=0, `dig`=0, frame counter=0.
  - Snapshot: value 0, size 0, empty=1, error=0, show_size=0.
  - Outputs: `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- Release is synchronous to `clk`. The first cycle after release drives digit 0 with "-".
- `an`, `seg`, `dp` are registered. They reflect the new `dig` one cycle after `tick`, and new snapshot data one cycle after the snapshot tick.
- Input changes between snapshots are ignored. Latency from an input change to display is at most 4·2^DIV_W + 1 cycles.
- Reset mid-frame blanks immediately. The snapshot is discarded.

## Configuration
- `SEG7_BLINK_EN` defined:
  - A BLINK_W-bit frame counter increments on `tick && dig==3`.
  - While the snapshot error flag is 1 and the counter MSB is 1, `an`=4'b1111.
  - The counter runs continuously and is not cleared on error.
- `SEG7_BLINK_EN` undefined: no frame counter; the error glyphs are steady.

## Structure
- `seg7_pkg` holds:
  - glyph constants `SEG_BLANK`, `SEG_DASH`, `SEG_E`, `SEG_R`;
  - the 16-entry hex font as a constant function;
  - the anode-off constant.
- Sub-module `seg7_font`: combinational nibble → active-low segment pattern. Instantiated once, fed by the selected nibble.

## Test plan
Benches run with DIV_W=2 (4 cycles per digit, 16 cycles per frame).
- Reset held, then released, with `empty`=1:
  - during reset, `an`=1111 and `seg`=7F;
  - after release, every digit shows `seg`=7'b0111111 ("-").
- `value`=16'h12AF, `empty`=0, one full frame later:
  - `an`=1110 → `seg`=0001110 (F);
  - `an`=1101 → 0001000 (A);
  - `an`=1011 → 0100100 (2);
  - `an`=0111 → 1111001 (1).
- `show_size`=1, `size`=7'd37 (0x25):
  - digit 0 = 0010010 (5) with `dp`=0;
  - digit 1 = 0100100 (2);
  - digits 3,2 = 7F.
- `value` changes from 16'h1111 to 16'h2222 while `dig`=1: the rest of that frame still shows "1"; the next frame shows "2" on all digits.
- `error`=1:
  - display shows E,r,r,blank (0000110, 0101111, 0101111, 1111111);
  - with `SEG7_BLINK_EN` and BLINK_W=2, `an`=1111 for frames 2-3 of every 4.
- Assert `rst_n` low mid-digit: `an`=1111 in the same cycle (asynchronous); the snapshot returns to empty.
